// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
//
// Shared definitions for the pipelined immediate extender:
//   - ext_mode_e : 2-bit extension mode (sign / zero / upper-load / branch)
//   - stage_t    : one pipeline stage record {valid, data} at the core's
//                  default datapath width
//   - depth_is_legal() : legality of the PIPE_DEPTH parameter
//
// Configuration macro referenced by users of this package:
//   IMM_EXT_BRANCH_EN - enables the branch-offset (shift by 2) mode.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

   // Default widths of the MIPS decode/execute datapath.
   localparam int IMM_EXT_DATA_W = 32;
   localparam int IMM_EXT_IMM_W  = 16;

   // Deepest pipe whose occupancy still fits the 2-bit out_count port.
   localparam int IMM_EXT_MAX_DEPTH = 3;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_LUI    = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_e;

   // One stage of the extension pipe at the default datapath width.
   typedef struct packed {
      logic                      valid;
      logic [IMM_EXT_DATA_W-1:0] data;
   } stage_t;

   function automatic bit depth_is_legal(input int depth);
      return (depth >= 1) && (depth <= IMM_EXT_MAX_DEPTH);
   endfunction

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
//
// Combinational immediate extender: widens an IMM_W-bit immediate to DATA_W
// bits according to the selected mode.
//
// Parameters:
//   DATA_W - output width (must be >= IMM_W + 2)
//   IMM_W  - immediate width
//
// Ports:
//   i_imm  in  IMM_W   raw immediate field
//   i_mode in  2       00 sign, 01 zero, 10 upper-load, 11 branch
//   o_data out DATA_W  extended value
//
// Configuration:
//   IMM_EXT_BRANCH_EN defined   - mode 11 sign-extends and shifts left by 2.
//   IMM_EXT_BRANCH_EN undefined - mode 11 behaves as mode 00 and no shifter
//                                 is built.
// -----------------------------------------------------------------------------
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16
) (
   input  logic [IMM_W-1:0]  i_imm,
   input  logic [1:0]        i_mode,
   output logic [DATA_W-1:0] o_data
);

   localparam int PAD_W = DATA_W - IMM_W;

   ext_mode_e         w_mode;
   logic [DATA_W-1:0] w_sext;
   logic [DATA_W-1:0] w_zext;
   logic [DATA_W-1:0] w_lui;

   assign w_mode = ext_mode_e'(i_mode);

   assign w_sext = {{PAD_W{i_imm[IMM_W-1]}}, i_imm};
   assign w_zext = {{PAD_W{1'b0}}, i_imm};
   assign w_lui  = {i_imm, {PAD_W{1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
   // Word-aligned branch offset: the two MSBs of the sign-extended value
   // fall off the top, so DATA_W must leave room for them.
   logic [DATA_W-1:0] w_branch;
   assign w_branch = {w_sext[DATA_W-3:0], 2'b00};
`endif

   always_comb begin
      // NOTE: every output of a combinational block gets a default before the
      // case so that no path leaves it unassigned and no latch is inferred.
      o_data = w_sext;
      case (w_mode)
         EXT_SIGN:   o_data = w_sext;
         EXT_ZERO:   o_data = w_zext;
         EXT_LUI:    o_data = w_lui;
`ifdef IMM_EXT_BRANCH_EN
         EXT_BRANCH: o_data = w_branch;
`else
         EXT_BRANCH: o_data = w_sext;
`endif
         default:    o_data = w_sext;
      endcase
   end

endmodule : imm_ext_core

// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//
// Pipelined immediate extender for the decode/execute path. The immediate is
// extended combinationally at the input and then carried through PIPE_DEPTH
// valid-tagged register stages that follow the core's stall and flush
// controls, so each result stays in lockstep with its instruction.
//
// Parameters:
//   DATA_W     - output width, >= IMM_W + 2            (default 32)
//   IMM_W      - immediate width                       (default 16)
//   PIPE_DEPTH - number of register stages, 1..3        (default 2)
//
// Ports:
//   clk        in  1       rising-edge clock
//   reset_n    in  1       synchronous active-low reset
//   in_valid   in  1       stage-0 input carries an instruction
//   in_imm     in  IMM_W   raw immediate field
//   in_mode    in  2       00 sign, 01 zero, 10 upper-load, 11 branch
//   stall      in  1       freeze every stage (input not captured)
//   flush      in  1       kill every in-flight entry (beats stall)
//   out_valid  out 1       last stage holds a live result
//   out_data   out DATA_W  result of the last stage (0 when not valid)
//   out_count  out 2       number of stages holding valid entries
//
// Configuration:
//   IMM_EXT_BRANCH_EN - when defined, mode 11 is the branch-offset extension;
//                       otherwise mode 11 is a plain sign extension.
// -----------------------------------------------------------------------------
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int IMM_W      = 16,
   parameter int PIPE_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [1:0]        in_mode,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_count
);

   // --------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // --------------------------------------------------------------------------
   if (!depth_is_legal(PIPE_DEPTH)) begin : g_bad_depth
      $error("imm_ext_pipe: PIPE_DEPTH must be in 1..3");
   end

   if (DATA_W < IMM_W + 2) begin : g_bad_width
      $error("imm_ext_pipe: DATA_W must be at least IMM_W + 2");
   end

   // Same layout as imm_ext_pkg::stage_t, sized by DATA_W.
   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
   } pipe_stage_t;

   localparam int LAST = PIPE_DEPTH - 1;

   // --------------------------------------------------------------------------
   // Stage-0 input: extension happens before the first register
   // --------------------------------------------------------------------------
   logic [DATA_W-1:0] w_ext;
   pipe_stage_t       w_in;

   imm_ext_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W)
   ) u_core (
      .i_imm  (in_imm),
      .i_mode (in_mode),
      .o_data (w_ext)
   );

   // An idle slot carries zero data so out_data is 0 whenever out_valid is 0.
   assign w_in.valid = in_valid;
   assign w_in.data  = in_valid ? w_ext : '0;

   // --------------------------------------------------------------------------
   // Stage registers
   // --------------------------------------------------------------------------
   pipe_stage_t r_stage [PIPE_DEPTH];
   logic [1:0]  r_count;
   logic [1:0]  w_count_next;

   // Occupancy after a normal shift: one entry may enter, one may leave.
   assign w_count_next = r_count + 2'(in_valid) - 2'(r_stage[LAST].valid);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's value from before this edge; a blocking
      // assignment here would let an entry ripple through several stages.
      if (!reset_n) begin
         // NOTE: the stage array is small and its data must read as 0 after
         // reset, so every entry is cleared, not only the valid bits.
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            r_stage[k] <= '0;
         end
         r_count <= '0;
      end else if (flush) begin
         // Flush wins over stall and drops the entry at the input as well.
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            r_stage[k] <= '0;
         end
         r_count <= '0;
      end else if (!stall) begin
         r_stage[0] <= w_in;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            r_stage[k].valid <= r_stage[k-1].valid;
            r_stage[k].data  <= r_stage[k-1].valid ? r_stage[k-1].data : '0;
         end
         r_count <= w_count_next;
      end
   end

   assign out_valid = r_stage[LAST].valid;
   assign out_data  = r_stage[LAST].data;
   assign out_count = r_count;

   // --------------------------------------------------------------------------
   // Invariants: the registered counter tracks the stage valids exactly and
   // an empty output slot never carries stale data.
   // --------------------------------------------------------------------------
   logic [PIPE_DEPTH-1:0] w_valid_vec;

   always_comb begin
      w_valid_vec = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         w_valid_vec[k] = r_stage[k].valid;
      end
   end

   a_count_matches_valids : assert property (
      @(posedge clk) r_count == 2'($countones(w_valid_vec))
   );

   a_count_bounded : assert property (
      @(posedge clk) 32'(r_count) <= PIPE_DEPTH
   );

   a_idle_data_zero : assert property (
      @(posedge clk) !r_stage[LAST].valid |-> (r_stage[LAST].data == '0)
   );

endmodule : imm_ext_pipe
